// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM encoding, header length,
// instruction-memory geometry and per-state output flags.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH  = 256;
  localparam int HDR_BYTES   = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_LOAD    = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4,
    S_ERR     = 3'd5
  } ld_state_t;

  typedef struct packed {
    logic cpu_rst;
    logic busy;
    logic done;
    logic err;
    logic ready;
  } ld_flags_t;

  function automatic ld_flags_t flags_of(ld_state_t s);
    ld_flags_t f;
    f = '{cpu_rst: 1'b1, busy: 1'b0, done: 1'b0,
          err: 1'b0, ready: 1'b0};
    unique case (s)
      S_HDR, S_LOAD: begin
        f.busy  = 1'b1;
        f.ready = 1'b1;
      end
      S_RUN: begin
        f.cpu_rst = 1'b0;
        f.done    = 1'b1;
      end
      S_ERR:   f.err = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus
// of the program loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte to 32-bit assembler; word_valid marks
// the cycle the 4th byte is accepted.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] sh;
  logic [1:0]  cnt;

  assign word_valid = in_valid && (cnt == 2'd3);
  assign word       = {sh, in_data};

  // Shift in accepted bytes; gaps simply hold the partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      sh  <= {sh[15:0], in_data};
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction
// memory, holding the CPU in reset until it is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  imem_loader_if.master bus,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [ADDR_W:0] words_loaded
);

  ld_state_t   state;
  ld_state_t   nxt;
  logic [1:0]  rst_q;
  logic        hdr_idx;
  logic [7:0]  hdr_hi;
  logic [15:0] n_words;
  logic [15:0] n_hdr;
  logic        acc;
  logic        hdr_done;
  logic        pk_in;
  logic        pk_valid;
  logic [31:0] pk_word;
  logic        last;

  assign acc      = bus.byte_valid && bus.byte_ready;
  assign n_hdr    = {hdr_hi, bus.byte_data};
  assign hdr_done = (state == S_HDR) && acc &&
                    (hdr_idx == 1'(HDR_BYTES - 1));
  assign pk_in    = (state == S_LOAD) && acc;
  assign last     = pk_valid &&
                    (17'(words_loaded) + 17'd1 == 17'(n_words));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state != S_LOAD),
    .in_valid   (pk_in),
    .in_data    (bus.byte_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (load_start && rst_q[1]) nxt = S_HDR;
      S_HDR:
        if (hdr_done) begin
          if (n_hdr == 16'd0)
            nxt = S_RELEASE;
          else if (32'(n_hdr) > 32'(DEPTH))
            nxt = S_ERR;
          else
            nxt = S_LOAD;
        end
      S_LOAD:
        if (last) nxt = S_RELEASE;
      S_RELEASE:
        nxt = S_RUN;
      S_RUN, S_ERR:
        if (load_start) nxt = S_HDR;
      default:
        nxt = S_IDLE;
    endcase
  end

  // State, registered flags, header capture and memory writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      rst_q          <= '0;
      cpu_rst        <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      words_loaded   <= '0;
      hdr_idx        <= 1'b0;
      hdr_hi         <= '0;
      n_words        <= '0;
    end else begin
      rst_q <= {rst_q[0], 1'b1};
      state <= nxt;
      {cpu_rst, busy, done, err, bus.byte_ready} <= flags_of(nxt);
      bus.imem_we <= pk_valid;
      if (pk_valid) begin
        bus.imem_addr  <= words_loaded[ADDR_W-1:0];
        bus.imem_wdata <= pk_word;
        words_loaded   <= words_loaded + 1'b1;
      end
      if (state == S_HDR && acc) begin
        hdr_idx <= ~hdr_idx;
        hdr_hi  <= bus.byte_data;
      end
      if (hdr_done) n_words <= n_hdr;
      if (nxt == S_HDR && state != S_HDR) begin
        words_loaded <= '0;
        hdr_idx      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table of
// header lengths plus hand-written corner sequences.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst;
  logic load_start;
  logic cpu_rst, busy, done, err;
  logic [8:0] words_loaded;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .bus          (bus),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int writes = 0;
  logic [39:0] sb[$];

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Scoreboard: every memory write must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      logic [39:0] e;
      writes++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {bus.imem_addr, bus.imem_wdata}, 40'hx);
      end else begin
        e = sb.pop_front();
        chk("imem_write", {bus.imem_addr, bus.imem_wdata}, e);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    int t;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    forever begin
      r = bus.byte_ready;
      tick();
      if (r) break;
      t++;
      if (t > 50) begin
        chk("ready_timeout", r, 1'b1);
        break;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic load_rand(input int n);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      sb.push_back({k[7:0], w});
      send_word(w);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_cpu_rst"}, cpu_rst, 1'b1);
    chk({tag, "_outs"}, {busy, done, err, bus.byte_ready, bus.imem_we},
        5'b0);
    chk({tag, "_bus"}, {bus.imem_addr, bus.imem_wdata}, 40'h0);
    chk({tag, "_words"}, words_loaded, 9'd0);
  endtask

  typedef struct {
    logic [15:0] n;
    logic        exp_err;
    logic        exp_done;
    logic [8:0]  exp_wl;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w0;
    logic [31:0] w;

    vecs[0] = '{16'd1,     1'b0, 1'b1, 9'd1};
    vecs[1] = '{16'd3,     1'b0, 1'b1, 9'd3};
    vecs[2] = '{16'd0,     1'b0, 1'b1, 9'd0};
    vecs[3] = '{16'd256,   1'b0, 1'b1, 9'd256};
    vecs[4] = '{16'd257,   1'b1, 1'b0, 9'd0};
    vecs[5] = '{16'h0101,  1'b1, 1'b0, 9'd0};

    rst = 1'b0;
    load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b1;
    repeat (3) tick();

    // Two-word program
    sb.push_back({8'd0, 32'h20080005});
    sb.push_back({8'd1, 32'hAC080050});
    w0 = writes;
    pulse_start();
    chk("hdr_busy_ready", {busy, bus.byte_ready, cpu_rst}, 3'b111);
    send_hdr(16'd2);
    send_word(32'h20080005);
    send_word(32'hAC080050);
    bus.byte_valid = 1'b0;
    chk("a_release", {cpu_rst, busy, done}, 3'b100);
    tick();
    chk("a_run", {cpu_rst, done, err}, 3'b010);
    chk("a_words", words_loaded, 9'd2);
    chk("a_writes", writes - w0, 2);

    // Table of header lengths
    foreach (vecs[i]) begin
      w0 = writes;
      pulse_start();
      chk("v_hdr", {busy, err, done, cpu_rst, words_loaded},
          {4'b1001, 9'd0});
      send_hdr(vecs[i].n);
      if (!vecs[i].exp_err) load_rand(int'(vecs[i].n));
      bus.byte_valid = 1'b0;
      chk("v_after", {cpu_rst, busy, done}, 3'b100);
      tick();
      chk("v_flags", {err, done, cpu_rst, bus.byte_ready},
          {vecs[i].exp_err, vecs[i].exp_done, ~vecs[i].exp_done, 1'b0});
      chk("v_words", words_loaded, vecs[i].exp_wl);
      chk("v_writes", writes - w0, int'(vecs[i].exp_wl));
      chk("v_sb_empty", sb.size(), 0);
    end

    // One word with a 3-cycle valid gap mid-word
    w = 32'hDEADBEEF;
    sb.push_back({8'd0, w});
    w0 = writes;
    pulse_start();
    chk("g_err_clear", {err, busy}, 2'b01);
    send_hdr(16'd1);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    bus.byte_valid = 1'b0;
    repeat (3) tick();
    chk("g_gap_nowrite", writes - w0, 0);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    bus.byte_valid = 1'b0;
    tick();
    chk("g_run", {done, cpu_rst}, 2'b10);
    chk("g_writes", writes - w0, 1);

    // Reset after 5 of 8 payload bytes
    w = 32'h01234567;
    sb.push_back({8'd0, w});
    w0 = writes;
    pulse_start();
    send_hdr(16'd2);
    send_word(w);
    send_byte(8'hAA);
    rst = 1'b0;
    #1;
    chk_reset_vals("abort");
    repeat (4) tick();
    bus.byte_valid = 1'b0;
    chk("abort_writes", writes - w0, 1);
    rst = 1'b1;
    repeat (3) tick();
    w = 32'hCAFEF00D;
    sb.push_back({8'd0, w});
    pulse_start();
    send_hdr(16'd1);
    send_word(w);
    bus.byte_valid = 1'b0;
    tick();
    chk("reload_run", {done, words_loaded}, {1'b1, 9'd1});
    chk("reload_writes", writes - w0, 2);

    // load_start while running restarts a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("restart", {cpu_rst, done, busy, words_loaded},
        {3'b101, 9'd0});
    w0 = writes;
    send_hdr(16'd2);
    load_rand(2);
    bus.byte_valid = 1'b0;
    tick();
    chk("restart_run", {done, cpu_rst, words_loaded}, {2'b10, 9'd2});
    chk("restart_writes", writes - w0, 2);
    chk("sb_final", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
